// File: rtl/fl_gen_pkg.sv
// Shared types and helpers for the FrameLink LFSR frame generator.
// Holds the default polynomial, FSM state encoding and frame shaping math.
package fl_gen_pkg;

    localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        SEND
    } state_t;

    typedef struct packed {
        logic [15:0] words;
        logic [15:0] rem;
    } frame_shape_t;

    // Number of bus words for len bytes and index of the last valid byte.
    function automatic frame_shape_t frame_shape(
        input logic [15:0] len,
        input int unsigned bytes
    );
        frame_shape_t s;
        s.words = 16'((32'(len) + bytes - 32'd1) / bytes);
        s.rem   = 16'((32'(len) - 32'd1) % bytes);
        return s;
    endfunction

endpackage

// File: rtl/fl_gen_lfsr.sv
// 32-bit right-shift Galois LFSR with seed load and single-step enable.
// A zero seed is replaced by 1 so the register never locks up.
module fl_gen_lfsr
    import fl_gen_pkg::*;
#(
    parameter logic [31:0] POLY     = LFSR_POLY_DEFAULT,
    parameter int          OUT_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [31:0]         seed,
    input  logic                step,
    output logic [OUT_BITS-1:0] next_bits
);

    logic [31:0] value;
    logic [31:0] next;

    assign next = {1'b0, value[31:1]} ^ (value[0] ? POLY : 32'd0);
    assign next_bits = OUT_BITS'(next);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 32'd1;
        end else if (load) begin
            value <= (seed == 32'd0) ? 32'd1 : seed;
        end else if (step) begin
            value <= next;
        end
    end

endmodule

// File: rtl/fl_lfsr_frame_gen.sv
// FrameLink single-part frame generator with LFSR-driven frame lengths.
// Payload byte j is j[7:0]; word 0 carries length and sequence number.
module fl_lfsr_frame_gen
    import fl_gen_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          MIN_LEN    = 64,
    parameter int          LEN_BITS   = 4,
    parameter logic [31:0] LFSR_POLY  = LFSR_POLY_DEFAULT,
    localparam int         BYTES      = DATA_WIDTH / 8,
    localparam int         REM_W      = $clog2(BYTES)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  STOP,
    input  logic [31:0]           SEED,
    input  logic [15:0]           FRAME_COUNT,
    output logic                  BUSY,
    output logic [15:0]           FRAMES_SENT,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [REM_W-1:0]      TX_REM,
    output logic                  TX_SOF_N,
    output logic                  TX_SOP_N,
    output logic                  TX_EOF_N,
    output logic                  TX_EOP_N,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N
);

    state_t              state;
    state_t              state_next;
    logic [LEN_BITS-1:0] lfsr_bits;
    logic [15:0]         len;
    logic [15:0]         word_cnt;
    logic [15:0]         frames_sent;
    logic [15:0]         frame_count;
    logic                stop_pend;
    logic                busy;
    logic [15:0]         words;
    logic [15:0]         rem_all;
    logic                idle_start;
    logic                xfer;
    logic                last;
    logic                eof_xfer;
    logic [15:0]         sent_next;
    logic                finish;
    logic                sof_n;
    logic                eof_n;

    assign {words, rem_all} = frame_shape(len, BYTES);

    assign idle_start = (state == IDLE) && START;
    assign xfer       = (state == SEND) && !TX_DST_RDY_N;
    assign last       = (word_cnt == words - 16'd1);
    assign eof_xfer   = xfer && last;
    assign sent_next  = frames_sent + 16'd1;
    assign finish     = eof_xfer &&
                        (stop_pend || STOP ||
                         (frame_count != 16'd0 &&
                          sent_next == frame_count));

    fl_gen_lfsr #(
        .POLY     (LFSR_POLY),
        .OUT_BITS (LEN_BITS)
    ) u_lfsr (
        .clk       (CLK),
        .reset     (RESET),
        .load      (idle_start),
        .seed      (SEED),
        .step      (state == PREP),
        .next_bits (lfsr_bits)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (START) state_next = PREP;
            PREP: state_next = SEND;
            SEND: if (eof_xfer) state_next = finish ? IDLE : PREP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            len         <= 16'd0;
            word_cnt    <= 16'd0;
            frames_sent <= 16'd0;
            frame_count <= 16'd0;
            stop_pend   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (idle_start) begin
                frame_count <= FRAME_COUNT;
                frames_sent <= 16'd0;
                stop_pend   <= 1'b0;
                busy        <= 1'b1;
            end
            if (state == PREP) begin
                len      <= 16'(MIN_LEN) + 16'(lfsr_bits);
                word_cnt <= 16'd0;
            end
            if (xfer) begin
                if (last) begin
                    frames_sent <= sent_next;
                end else begin
                    word_cnt <= word_cnt + 16'd1;
                end
            end
            if (busy && STOP) begin
                stop_pend <= 1'b1;
            end
            if (finish) begin
                busy      <= 1'b0;
                stop_pend <= 1'b0;
            end
        end
    end

    // The sequence number always equals frames_sent, so one register serves both.
    always_comb begin
        TX_SRC_RDY_N = 1'b1;
        sof_n        = 1'b1;
        eof_n        = 1'b1;
        TX_REM       = '0;
        TX_DATA      = '0;
        if (state == SEND) begin
            TX_SRC_RDY_N = 1'b0;
            sof_n        = (word_cnt != 16'd0);
            eof_n        = !last;
            if (last) begin
                TX_REM = REM_W'(rem_all);
            end
            for (int k = 0; k < BYTES; k++) begin
                TX_DATA[8*k +: 8] =
                    8'(32'(word_cnt) * 32'(BYTES) + 32'(k));
            end
            if (word_cnt == 16'd0) begin
                TX_DATA[15:0]  = len;
                TX_DATA[31:16] = frames_sent;
            end
        end
    end

    assign TX_SOF_N    = sof_n;
    assign TX_SOP_N    = sof_n;
    assign TX_EOF_N    = eof_n;
    assign TX_EOP_N    = eof_n;
    assign BUSY        = busy;
    assign FRAMES_SENT = frames_sent;

endmodule

// File: doc/fl_lfsr_frame_gen.md
Name: fl_lfsr_frame_gen

Overview:
Hardware FrameLink frame generator for the netcope adder verification environment. It sits directly upstream of the FrameLink input of the DUT and produces the same single-part frames the software generator/driver path produces. The host only programs a seed and a frame count. Frame lengths are pseudo-random from an LFSR. Payload is deterministic, so the downstream monitor and transaction table can check every byte.

Parameters:
DATA_WIDTH, 64, FrameLink data width in bits; a multiple of 32, at least 32
MIN_LEN, 64, minimum frame length in bytes; at least 4
LEN_BITS, 4, number of LFSR bits added to MIN_LEN; length range is MIN_LEN .. MIN_LEN+2^LEN_BITS-1
LFSR_POLY, 32'h80200003, right-shift Galois mask for x^32+x^22+x^2+x+1

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
START  in  1  single-cycle pulse; begins generation when idle
STOP  in  1  single-cycle pulse; ends generation after the current frame
SEED  in  32  LFSR seed, sampled on an accepted START
FRAME_COUNT  in  16  number of frames to send; 0 means unlimited until STOP
BUSY  out  1  high from an accepted START until the last EOF transfer
FRAMES_SENT  out  16  completed frames since the last START; wraps at 16 bits
TX_DATA  out  DATA_WIDTH  frame data; byte j occupies bits [8j+7:8j]
TX_REM  out  log2(DATA_WIDTH/8)  index of the last valid byte; meaningful only on EOF
TX_SOF_N, TX_SOP_N  out  1  start of frame and start of part (identical, active low)
TX_EOF_N, TX_EOP_N  out  1  end of frame and end of part (identical, active low)
TX_SRC_RDY_N  out  1  source ready, active low
TX_DST_RDY_N  in  1  destination ready, active low

Behaviour:
- Reset values:
  - TX_SRC_RDY_N, TX_SOF_N, TX_SOP_N, TX_EOF_N, TX_EOP_N = 1.
  - TX_DATA = 0, TX_REM = 0, BUSY = 0, FRAMES_SENT = 0.
  - LFSR = 1; FSM in IDLE.
- Transfer rule:
  - A word is transferred when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0 in the same cycle.
  - While TX_SRC_RDY_N=0 and TX_DST_RDY_N=1, all TX_* outputs hold stable.
- FSM states: IDLE, PREP, SEND.
- IDLE:
  - START loads LFSR <= SEED, or 1 if SEED=0.
  - START also latches FRAME_COUNT, clears FRAMES_SENT and the sequence number, sets BUSY, and goes to PREP.
  - STOP in IDLE is ignored.
- PREP (one cycle, TX_SRC_RDY_N=1):
  - LFSR steps once: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0).
  - len <= MIN_LEN + next_lfsr[LEN_BITS-1:0], using the post-step value.
  - Word counter is cleared; next state is SEND.
- SEND (TX_SRC_RDY_N=0):
  - Word i carries bytes 8i.. of the frame; generic byte j = j[7:0] (DATA_WIDTH=64 shown).
  - Word 0 bits [15:0] are overwritten with len, bits [31:16] with the sequence number.
  - SOF/SOP are low on word 0.
  - EOF/EOP are low on word ceil(len/8)-1, with TX_REM = (len-1) mod 8.
- On the EOF transfer:
  - FRAMES_SENT and the sequence number increment.
  - If a stop is pending, or FRAME_COUNT≠0 and the new FRAMES_SENT equals FRAME_COUNT: go to IDLE and clear BUSY in the same edge.
  - Otherwise go to PREP. The inter-frame gap is exactly one cycle.
- STOP while BUSY sets a pending flag. The current frame always completes. The flag clears on return to IDLE.
- START while BUSY is ignored.
- A START in the same cycle as the final EOF transfer is ignored.
- RESET mid-frame: the frame is truncated with no EOF, and all reset values apply on the next edge.
- Counters wrap modulo 2^16. FRAME_COUNT is compared against FRAMES_SENT as it wraps.

Decomposition:
- Shared package fl_gen_pkg holds:
  - the LFSR default polynomial constant;
  - the FSM state enum (IDLE, PREP, SEND);
  - the function computing word count and REM from len.
- One sub-module, fl_gen_lfsr: 32-bit Galois LFSR with load, seed-zero substitution and step enable.

Test Plan:
- Basic run (TX_DST_RDY_N=0 throughout):
  - Stimulus: SEED=1, FRAME_COUNT=2, MIN_LEN=64, LEN_BITS=4.
  - Frame 0: LFSR=0x80200003, len=67, 9 words, word0=0x0706050400000043, EOF REM=2.
  - Frame 1: LFSR=0xC0300002, len=66, word0=0x0706050400010042, REM=1.
  - Then BUSY=0 and FRAMES_SENT=2.
- Backpressure:
  - Stimulus: same run with TX_DST_RDY_N toggling 1/0 every cycle.
  - Identical word sequence, with outputs held stable in every stalled cycle.
- Stop mid-frame:
  - Stimulus: FRAME_COUNT=0, STOP pulsed on word 3 of frame 1.
  - Frame 1 completes with EOF, then IDLE with FRAMES_SENT=2.
- Seed zero:
  - Stimulus: SEED=0.
  - Output identical to SEED=1.
  - START issued while BUSY has no effect on the sequence.
- Reset mid-frame:
  - Stimulus: RESET on word 4.
  - Next cycle: TX_SRC_RDY_N=1, BUSY=0, FRAMES_SENT=0.
  - A subsequent START with SEED=1 reproduces frame 0 exactly.
